// File: rtl/retire_commit.sv
// In-order retire FIFO: commits register writers, frees old pregs, issues one store per cycle.
// Optional feature macro: RETIRE_PERF_EN (retired_count / st_wait_cycles counters).
package retire_commit_pkg;
    localparam int PREG_W = 6;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic RegWrite;
        logic MemWrite;
    } ctrlStruct;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [PREG_W-1:0] rd;
        logic [PREG_W-1:0] rd_old;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   mem_data;
        ctrlStruct         control;
    } robEntryStruct;
endpackage

module retire_commit #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = retire_commit_pkg::PREG_W,
    parameter int XLEN   = retire_commit_pkg::XLEN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  retire_commit_pkg::robEntryStruct rob_in1,
    input  retire_commit_pkg::robEntryStruct rob_in2,
    output logic                            stall,
    output logic                            commit_valid1,
    output logic                            commit_valid2,
    output logic [PREG_W-1:0]               commit_reg1,
    output logic [PREG_W-1:0]               commit_reg2,
    output logic [XLEN-1:0]                 commit_pc1,
    output logic [XLEN-1:0]                 commit_pc2,
    output logic                            free_valid1,
    output logic                            free_valid2,
    output logic [PREG_W-1:0]               free_reg1,
    output logic [PREG_W-1:0]               free_reg2,
    output logic                            st_valid,
    output logic [XLEN-1:0]                 st_addr,
    output logic [XLEN-1:0]                 st_data,
    input  logic                            st_ready,
    output logic                            overflow,
    output logic [31:0]                     retired_count,
    output logic [31:0]                     st_wait_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [CNT_W:0]    spc_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [XLEN-1:0]   xlen_t;

    retire_commit_pkg::robEntryStruct r_fifo [DEPTH];
    ptr_t  r_head;
    ptr_t  r_tail;
    cnt_t  r_count;
    logic  r_overflow;

    logic  r_cv1, r_cv2;
    preg_t r_creg1, r_creg2, r_freg1, r_freg2;
    xlen_t r_cpc1, r_cpc2;

    retire_commit_pkg::robEntryStruct w_h0, w_h1;
    ptr_t       w_head1, w_tail1;
    logic       w_h0_vld, w_h1_vld, w_h0_ret, w_h1_ret;
    logic       w_req1, w_req2, w_acc1, w_acc2, w_drop;
    logic [1:0] w_deq, w_enq;
    spc_t       w_space;
    logic       w_unused;

    assign w_head1  = r_head + ptr_t'(1);
    assign w_tail1  = r_tail + ptr_t'(1);
    assign w_h0     = r_fifo[r_head];
    assign w_h1     = r_fifo[w_head1];
    assign w_h0_vld = (r_count != '0);
    assign w_h1_vld = (r_count >= cnt_t'(2));

    // Only the head may be a store; a store in H1 waits so one store retires per cycle.
    assign w_h0_ret = w_h0_vld && (!w_h0.control.MemWrite || st_ready);
    assign w_h1_ret = w_h0_ret && w_h1_vld && !w_h1.control.MemWrite;
    assign w_deq    = {1'b0, w_h0_ret} + {1'b0, w_h1_ret};

    // Space counts slots freed by this edge's dequeue, so a full FIFO retiring 2 accepts 2.
    assign w_req1   = rob_in1.valid;
    assign w_req2   = rob_in1.valid && rob_in2.valid;
    assign w_space  = spc_t'(DEPTH) - spc_t'(r_count) + spc_t'(w_deq);
    assign w_acc1   = w_req1 && (w_space >= spc_t'(1));
    assign w_acc2   = w_req2 && (w_space >= spc_t'(2));
    assign w_drop   = (w_req1 && !w_acc1) || (w_req2 && !w_acc2);
    assign w_enq    = {1'b0, w_acc1} + {1'b0, w_acc2};

    assign w_unused = ^{w_h0.valid, w_h1.valid, w_h1.result, w_h1.mem_data};

    always_ff @(posedge clk) begin
        if (w_acc1) r_fifo[r_tail]  <= rob_in1;
        if (w_acc2) r_fifo[w_tail1] <= rob_in2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head     <= r_head + ptr_t'(w_deq);
            r_tail     <= r_tail + ptr_t'(w_enq);
            r_count    <= r_count + cnt_t'(w_enq) - cnt_t'(w_deq);
            r_overflow <= r_overflow | w_drop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cv1   <= 1'b0;
            r_cv2   <= 1'b0;
            r_creg1 <= '0;
            r_creg2 <= '0;
            r_freg1 <= '0;
            r_freg2 <= '0;
            r_cpc1  <= '0;
            r_cpc2  <= '0;
        end else begin
            r_cv1 <= w_h0_ret && w_h0.control.RegWrite;
            r_cv2 <= w_h1_ret && w_h1.control.RegWrite;
            if (w_h0_ret) begin
                r_creg1 <= preg_t'(w_h0.rd);
                r_freg1 <= preg_t'(w_h0.rd_old);
                r_cpc1  <= xlen_t'(w_h0.pc);
            end
            if (w_h1_ret) begin
                r_creg2 <= preg_t'(w_h1.rd);
                r_freg2 <= preg_t'(w_h1.rd_old);
                r_cpc2  <= xlen_t'(w_h1.pc);
            end
        end
    end

    assign stall         = (r_count >= cnt_t'(DEPTH - 2));
    assign overflow      = r_overflow;
    assign commit_valid1 = r_cv1;
    assign commit_valid2 = r_cv2;
    assign commit_reg1   = r_creg1;
    assign commit_reg2   = r_creg2;
    assign commit_pc1    = r_cpc1;
    assign commit_pc2    = r_cpc2;
    assign free_valid1   = r_cv1;
    assign free_valid2   = r_cv2;
    assign free_reg1     = r_freg1;
    assign free_reg2     = r_freg2;

    // Head is frozen while the store waits, so address/data hold without extra registers.
    assign st_valid      = w_h0_vld && w_h0.control.MemWrite;
    assign st_addr       = xlen_t'(w_h0.result);
    assign st_data       = xlen_t'(w_h0.mem_data);

`ifdef RETIRE_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_st_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
            r_st_wait <= '0;
        end else begin
            r_retired <= r_retired + 32'(w_deq);
            if (st_valid && !st_ready) r_st_wait <= r_st_wait + 32'd1;
        end
    end

    assign retired_count  = r_retired;
    assign st_wait_cycles = r_st_wait;
`else
    assign retired_count  = '0;
    assign st_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_retire_commit.sv
// Bench for retire_commit: vector table for single-pair retirement, hand sequences for
// store back-pressure, fill/overflow and reset, with a commit/store scoreboard.
module tb_retire_commit;
    import retire_commit_pkg::*;
    typedef robEntryStruct rob_t;

    logic        clk = 1'b0;
    logic        reset;
    rob_t        rob_in1, rob_in2;
    logic        st_ready;
    logic        stall, overflow, st_valid;
    logic        commit_valid1, commit_valid2, free_valid1, free_valid2;
    logic [5:0]  commit_reg1, commit_reg2, free_reg1, free_reg2;
    logic [31:0] commit_pc1, commit_pc2, st_addr, st_data;
    logic [31:0] retired_count, st_wait_cycles;

    always #5 clk = ~clk;

    retire_commit dut (
        .clk(clk), .reset(reset), .rob_in1(rob_in1), .rob_in2(rob_in2), .stall(stall),
        .commit_valid1(commit_valid1), .commit_valid2(commit_valid2),
        .commit_reg1(commit_reg1), .commit_reg2(commit_reg2),
        .commit_pc1(commit_pc1), .commit_pc2(commit_pc2),
        .free_valid1(free_valid1), .free_valid2(free_valid2),
        .free_reg1(free_reg1), .free_reg2(free_reg2),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .overflow(overflow), .retired_count(retired_count), .st_wait_cycles(st_wait_cycles)
    );

    typedef struct { logic [5:0] rd; logic [5:0] rd_old; logic [31:0] pc; } cexp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } sexp_t;
    typedef struct {
        rob_t in1; rob_t in2; logic st; logic cv1; logic cv2;
        logic [5:0] r1; logic [5:0] r2; logic [5:0] f1; logic [5:0] f2;
    } vec_t;

    cexp_t cq[$];
    sexp_t sq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rob_t mk(input logic [31:0] pc, input logic [5:0] rd, input logic [5:0] rd_old,
                                input logic [31:0] res, input logic [31:0] md,
                                input logic rw, input logic mw);
        rob_t e;
        e = '0;
        e.valid = 1'b1; e.pc = pc; e.rd = rd; e.rd_old = rd_old;
        e.result = res; e.mem_data = md;
        e.control.RegWrite = rw; e.control.MemWrite = mw;
        return e;
    endfunction

    function automatic rob_t alu(input logic [31:0] pc, input logic [5:0] rd, input logic [5:0] rd_old);
        return mk(pc, rd, rd_old, pc ^ 32'h5a5a, 32'h0, 1'b1, 1'b0);
    endfunction

    function automatic rob_t sto(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        return mk(pc, 6'd0, 6'd0, addr, data, 1'b0, 1'b1);
    endfunction

    task automatic monitor();
        cexp_t c;
        sexp_t s;
        if (!reset) return;
        if (commit_valid1) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL commit1_unexpected: got reg %0d expected no commit", commit_reg1);
            end else begin
                c = cq.pop_front();
                chk("sb_commit_reg1", 32'(commit_reg1), 32'(c.rd));
                chk("sb_commit_pc1", commit_pc1, c.pc);
                chk("sb_free_reg1", 32'(free_reg1), 32'(c.rd_old));
                chk("sb_free_valid1", 32'(free_valid1), 32'd1);
            end
        end
        if (commit_valid2) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL commit2_unexpected: got reg %0d expected no commit", commit_reg2);
            end else begin
                c = cq.pop_front();
                chk("sb_commit_reg2", 32'(commit_reg2), 32'(c.rd));
                chk("sb_commit_pc2", commit_pc2, c.pc);
                chk("sb_free_reg2", 32'(free_reg2), 32'(c.rd_old));
                chk("sb_free_valid2", 32'(free_valid2), 32'd1);
            end
        end
        if (st_valid && st_ready) begin
            if (sq.size() == 0) begin
                checks++; errors++;
                $display("FAIL store_unexpected: got addr 0x%0h expected no store", st_addr);
            end else begin
                s = sq.pop_front();
                chk("sb_st_addr", st_addr, s.addr);
                chk("sb_st_data", st_data, s.data);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input rob_t e);
        cexp_t c;
        sexp_t s;
        if (e.control.RegWrite) begin
            c.rd = e.rd; c.rd_old = e.rd_old; c.pc = e.pc;
            cq.push_back(c);
        end
        if (e.control.MemWrite) begin
            s.addr = e.result; s.data = e.mem_data;
            sq.push_back(s);
        end
    endtask

    // ndrop: how many of the youngest presented entries the FIFO is expected to drop
    task automatic drive(input rob_t e1, input rob_t e2, input int ndrop);
        rob_t acc[2];
        int   n;
        n = 0;
        if (e1.valid) begin
            acc[n] = e1; n++;
            if (e2.valid) begin acc[n] = e2; n++; end
        end
        n = n - ndrop;
        for (int i = 0; i < n; i++) push_exp(acc[i]);
        rob_in1 = e1;
        rob_in2 = e2;
        tick();
        rob_in1 = '0;
        rob_in2 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rob_in1 = '0;
        rob_in2 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cq.delete();
        sq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{alu(32'h100, 6'd5, 6'd12), alu(32'h104, 6'd6, 6'd13), 1'b0, 1'b1, 1'b1, 6'd5, 6'd6, 6'd12, 6'd13};
        vecs[1] = '{alu(32'h108, 6'd9, 6'd30), '0, 1'b0, 1'b1, 1'b0, 6'd9, 6'd0, 6'd30, 6'd0};
        vecs[2] = '{'0, alu(32'h10c, 6'd17, 6'd18), 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0};
        vecs[3] = '{'0, sto(32'h110, 32'hdead0000, 32'h1), 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0};
        vecs[4] = '{mk(32'h114, 6'd2, 6'd3, 32'h0, 32'h0, 1'b0, 1'b0), alu(32'h118, 6'd3, 6'd40),
                    1'b0, 1'b0, 1'b1, 6'd0, 6'd3, 6'd0, 6'd40};
        vecs[5] = '{sto(32'h11c, 32'h8000, 32'hcafe), alu(32'h120, 6'd4, 6'd41),
                    1'b1, 1'b0, 1'b1, 6'd0, 6'd4, 6'd0, 6'd41};
        vecs[6] = '{alu(32'h1fc, 6'd63, 6'd0), alu(32'h200, 6'd0, 6'd63), 1'b0, 1'b1, 1'b1, 6'd63, 6'd0, 6'd0, 6'd63};
        vecs[7] = '{sto(32'h204, 32'h9000, 32'hbeef), '0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0};

        reset = 1'b0;
        rob_in1 = '0;
        rob_in2 = '0;
        st_ready = 1'b1;
        #12;
        chk("rst_commit_valid1", 32'(commit_valid1), 32'd0);
        chk("rst_commit_valid2", 32'(commit_valid2), 32'd0);
        chk("rst_free_valid1", 32'(free_valid1), 32'd0);
        chk("rst_free_valid2", 32'(free_valid2), 32'd0);
        chk("rst_commit_reg1", 32'(commit_reg1), 32'd0);
        chk("rst_commit_pc1", commit_pc1, 32'd0);
        chk("rst_st_valid", 32'(st_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_retired_count", retired_count, 32'd0);
        chk("rst_st_wait", st_wait_cycles, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].in1, vecs[i].in2, 0);
            chk($sformatf("row%0d_st_valid", i), 32'(st_valid), 32'(vecs[i].st));
            chk($sformatf("row%0d_stall", i), 32'(stall), 32'd0);
            tick();
            chk($sformatf("row%0d_cv1", i), 32'(commit_valid1), 32'(vecs[i].cv1));
            chk($sformatf("row%0d_cv2", i), 32'(commit_valid2), 32'(vecs[i].cv2));
            if (vecs[i].cv1) begin
                chk($sformatf("row%0d_reg1", i), 32'(commit_reg1), 32'(vecs[i].r1));
                chk($sformatf("row%0d_free1", i), 32'(free_reg1), 32'(vecs[i].f1));
            end
            if (vecs[i].cv2) begin
                chk($sformatf("row%0d_reg2", i), 32'(commit_reg2), 32'(vecs[i].r2));
                chk($sformatf("row%0d_free2", i), 32'(free_reg2), 32'(vecs[i].f2));
            end
        end
        tick();

        // Store held off for three edges with an ALU op queued behind it
        do_reset();
        st_ready = 1'b0;
        drive(sto(32'h300, 32'ha000, 32'hd000), alu(32'h304, 6'd7, 6'd20), 0);
        for (int k = 0; k < 3; k++) begin
            chk("wait_st_valid", 32'(st_valid), 32'd1);
            chk("wait_st_addr", st_addr, 32'ha000);
            chk("wait_st_data", st_data, 32'hd000);
            chk("wait_no_commit2", 32'(commit_valid2), 32'd0);
            tick();
        end
        chk("wait_st_valid4", 32'(st_valid), 32'd1);
        chk("wait_st_addr4", st_addr, 32'ha000);
        st_ready = 1'b1;
        tick();
        chk("after_st_valid", 32'(st_valid), 32'd0);
        chk("after_cv1", 32'(commit_valid1), 32'd0);
        chk("after_cv2", 32'(commit_valid2), 32'd1);
        chk("after_reg2", 32'(commit_reg2), 32'd7);
`ifdef RETIRE_PERF_EN
        chk("perf_st_wait", st_wait_cycles, 32'd3);
        chk("perf_retired", retired_count, 32'd2);
`else
        chk("perf_st_wait_off", st_wait_cycles, 32'd0);
        chk("perf_retired_off", retired_count, 32'd0);
`endif
        tick();

        // Two stores enqueued together retire on consecutive edges
        drive(sto(32'h310, 32'hb0, 32'hb1), sto(32'h314, 32'hc0, 32'hc1), 0);
        chk("ss_first_valid", 32'(st_valid), 32'd1);
        chk("ss_first_addr", st_addr, 32'hb0);
        tick();
        chk("ss_second_valid", 32'(st_valid), 32'd1);
        chk("ss_second_addr", st_addr, 32'hc0);
        chk("ss_second_data", st_data, 32'hc1);
        tick();
        chk("ss_done", 32'(st_valid), 32'd0);

        // Fill to DEPTH behind a blocked store, then retire 2 and accept 2 at full
        do_reset();
        st_ready = 1'b0;
        drive(sto(32'h400, 32'h4000, 32'h44), alu(32'h404, 6'd10, 6'd50), 0);
        drive(alu(32'h408, 6'd11, 6'd51), alu(32'h40c, 6'd12, 6'd52), 0);
        chk("fill4_stall", 32'(stall), 32'd0);
        drive(alu(32'h410, 6'd13, 6'd53), alu(32'h414, 6'd14, 6'd54), 0);
        chk("fill6_stall", 32'(stall), 32'd1);
        drive(alu(32'h418, 6'd15, 6'd55), alu(32'h41c, 6'd16, 6'd56), 0);
        chk("fill8_stall", 32'(stall), 32'd1);
        chk("fill8_overflow", 32'(overflow), 32'd0);
        st_ready = 1'b1;
        drive(alu(32'h420, 6'd17, 6'd57), alu(32'h424, 6'd18, 6'd58), 0);
        chk("full_swap_overflow", 32'(overflow), 32'd0);
        chk("full_swap_stall", 32'(stall), 32'd1);
        repeat (6) tick();
        chk("drain_stall", 32'(stall), 32'd0);
        chk("drain_overflow", 32'(overflow), 32'd0);
        chk("drain_commit_q", 32'(cq.size()), 32'd0);
        chk("drain_store_q", 32'(sq.size()), 32'd0);

        // Overflow: a 2-entry push into a full, blocked FIFO is dropped
        do_reset();
        st_ready = 1'b0;
        drive(sto(32'h500, 32'h5000, 32'h55), alu(32'h504, 6'd20, 6'd40), 0);
        drive(alu(32'h508, 6'd21, 6'd41), alu(32'h50c, 6'd22, 6'd42), 0);
        drive(alu(32'h510, 6'd23, 6'd43), alu(32'h514, 6'd24, 6'd44), 0);
        drive(alu(32'h518, 6'd25, 6'd45), alu(32'h51c, 6'd26, 6'd46), 0);
        chk("ovf_pre", 32'(overflow), 32'd0);
        drive(alu(32'h520, 6'd27, 6'd47), alu(32'h524, 6'd28, 6'd48), 2);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_stall", 32'(stall), 32'd1);
        chk("ovf_st_valid", 32'(st_valid), 32'd1);
        st_ready = 1'b1;
        repeat (6) tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_drain_stall", 32'(stall), 32'd0);
        chk("ovf_commit_q", 32'(cq.size()), 32'd0);
        chk("ovf_store_q", 32'(sq.size()), 32'd0);

        // Asynchronous reset while a store waits at head with count 5
        do_reset();
        chk("rst_clears_overflow", 32'(overflow), 32'd0);
        st_ready = 1'b0;
        drive(sto(32'h600, 32'h6000, 32'h66), alu(32'h604, 6'd31, 6'd33), 0);
        drive(sto(32'h608, 32'h7000, 32'h77), alu(32'h60c, 6'd32, 6'd34), 0);
        drive(alu(32'h610, 6'd35, 6'd36), alu(32'h614, 6'd37, 6'd38), 0);
        chk("mid_stall6", 32'(stall), 32'd1);
        st_ready = 1'b1;
        drive(alu(32'h618, 6'd39, 6'd40), '0, 0);
        st_ready = 1'b0;
        chk("mid_stall5", 32'(stall), 32'd0);
        chk("mid_st_valid", 32'(st_valid), 32'd1);
        chk("mid_st_addr", st_addr, 32'h7000);
        chk("mid_cv2", 32'(commit_valid2), 32'd1);
        chk("mid_reg2", 32'(commit_reg2), 32'd31);
        chk("mid_free2", 32'(free_reg2), 32'd33);
        #2;
        reset = 1'b0;
        #1;
        chk("async_st_valid", 32'(st_valid), 32'd0);
        chk("async_cv1", 32'(commit_valid1), 32'd0);
        chk("async_cv2", 32'(commit_valid2), 32'd0);
        chk("async_fv2", 32'(free_valid2), 32'd0);
        chk("async_reg2", 32'(commit_reg2), 32'd0);
        chk("async_free_reg2", 32'(free_reg2), 32'd0);
        chk("async_stall", 32'(stall), 32'd0);
        chk("async_perf", st_wait_cycles, 32'd0);
        do_reset();
        st_ready = 1'b1;
        tick();
        chk("post_rst_no_replay", 32'(st_valid), 32'd0);
        chk("post_rst_no_commit", 32'(commit_valid1), 32'd0);
        drive(alu(32'h700, 6'd42, 6'd43), '0, 0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        tick();
        chk("post_rst_cv1", 32'(commit_valid1), 32'd1);
        chk("post_rst_reg1", 32'(commit_reg1), 32'd42);
        chk("post_rst_cv2", 32'(commit_valid2), 32'd0);
        tick();
        chk("final_commit_q", 32'(cq.size()), 32'd0);
        chk("final_store_q", 32'(sq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
